// File: rtl/alsu_arb_pkg.sv
// Shared types and constants for the ALSU arbiter slice.
//   alsu_ctrl_t : ALSU control bundle, MSB..LSB = cin, serial_in, direction,
//                 red_op_a, red_op_b, bypass_a, bypass_b
//   arb_state_e : sequencer states
//   OP_*        : ALSU opcode encodings
package alsu_arb_pkg;

    localparam int unsigned OPC_W  = 3;
    localparam int unsigned OPND_W = 3;
    localparam int unsigned CTRL_W = 7;
    localparam int unsigned OUT_W  = 6;
    localparam int unsigned LEDS_W = 16;

    localparam logic [OPC_W-1:0] OP_OR     = 3'd0;
    localparam logic [OPC_W-1:0] OP_XOR    = 3'd1;
    localparam logic [OPC_W-1:0] OP_ADD    = 3'd2;
    localparam logic [OPC_W-1:0] OP_MULT   = 3'd3;
    localparam logic [OPC_W-1:0] OP_SHIFT  = 3'd4;
    localparam logic [OPC_W-1:0] OP_ROTATE = 3'd5;

    typedef struct packed {
        logic cin;
        logic serial_in;
        logic direction;
        logic red_op_a;
        logic red_op_b;
        logic bypass_a;
        logic bypass_b;
    } alsu_ctrl_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    // Opcodes the ALSU rejects (it blinks its leds for these).
    function automatic logic is_reserved_op(input logic [OPC_W-1:0] op);
        return (op > OP_ROTATE);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant.
//   req        : request vector
//   last_grant : index granted most recently; search starts one above it
//   grant      : one-hot grant (zero when no request)
//   grant_idx  : encoded grant index (0 when no request)
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    logic            found;
    logic [ID_W-1:0] idx;

    // Walk last_grant+1 .. last_grant+NUM_REQ (mod NUM_REQ); first hit wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((32'(last_grant) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/alsu_arbiter.sv
// Shares one ALSU between NUM_REQ requesters: round-robin accept, drive the
// ALSU inputs, wait ALSU_LAT cycles, capture the result, return a tagged
// response with backpressure.
//   clk, reset      : clock, synchronous active-low reset
//   req_*           : per-requester valid/ready and operation payload
//   alsu_*  (out)   : registered ALSU operand/control drive
//   alsu_out, leds  : ALSU result and invalid-operation indication
//   rsp_*           : response channel (valid/ready, id, result, error)
// Build option: define ALSU_ARB_ERR_EN to register rsp_err from alsu_leds;
// otherwise rsp_err is constant 0 and alsu_leds is ignored.
module alsu_arbiter
    import alsu_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 2,
    parameter int unsigned ALSU_LAT = 2,
    parameter int unsigned ID_W     = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0][OPC_W-1:0]  req_opcode,
    input  logic [NUM_REQ-1:0][OPND_W-1:0] req_a,
    input  logic [NUM_REQ-1:0][OPND_W-1:0] req_b,
    input  alsu_ctrl_t [NUM_REQ-1:0]       req_ctrl,
    output logic [OPC_W-1:0]               alsu_opcode,
    output logic signed [OPND_W-1:0]       alsu_a,
    output logic signed [OPND_W-1:0]       alsu_b,
    output alsu_ctrl_t                     alsu_ctrl,
    input  logic [OUT_W-1:0]               alsu_out,
    input  logic [LEDS_W-1:0]              alsu_leds,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [ID_W-1:0]                rsp_id,
    output logic [OUT_W-1:0]               rsp_out,
    output logic                           rsp_err
);

    localparam int unsigned CNT_W = (ALSU_LAT > 1) ? $clog2(ALSU_LAT) : 1;

    arb_state_e          state;
    arb_state_e          state_next;
    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     grant_idx;
    logic [ID_W-1:0]     last_grant;
    logic [CNT_W-1:0]    wait_cnt;
    logic                accept;
    logic                capture;

    // Grant selection
    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, ready and strobes; ready is masked while reset is low
    always_comb begin
        state_next = state;
        req_ready  = '0;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (reset) begin
                    req_ready = grant;
                end
                accept = |(req_valid & req_ready);
                if (accept) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (wait_cnt == '0) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operation latch, grant pointer and response tag
    always_ff @(posedge clk) begin
        if (!reset) begin
            alsu_opcode <= '0;
            alsu_a      <= '0;
            alsu_b      <= '0;
            alsu_ctrl   <= '0;
            rsp_id      <= '0;
            last_grant  <= ID_W'(NUM_REQ - 1);
        end else if (accept) begin
            alsu_opcode <= req_opcode[grant_idx];
            alsu_a      <= req_a[grant_idx];
            alsu_b      <= req_b[grant_idx];
            alsu_ctrl   <= req_ctrl[grant_idx];
            rsp_id      <= grant_idx;
            last_grant  <= grant_idx;
        end
    end

    // Latency counter: loaded in ISSUE, counts down through WAIT
    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (state == ISSUE) begin
            wait_cnt <= CNT_W'(ALSU_LAT - 1);
        end else if ((state == WAIT) && (wait_cnt != '0)) begin
            wait_cnt <= wait_cnt - CNT_W'(1);
        end
    end

    // Response result and valid; valid mirrors residency in RESP
    always_ff @(posedge clk) begin
        if (!reset) begin
            rsp_out   <= '0;
            rsp_valid <= 1'b0;
        end else begin
            if (capture) begin
                rsp_out <= alsu_out;
            end
            rsp_valid <= (state_next == RESP);
        end
    end

`ifdef ALSU_ARB_ERR_EN
    // Error flag sampled alongside the result
    always_ff @(posedge clk) begin
        if (!reset) begin
            rsp_err <= 1'b0;
        end else if (capture) begin
            rsp_err <= (alsu_leds != '0);
        end
    end
`else
    logic unused_leds;
    assign unused_leds = ^alsu_leds;
    assign rsp_err     = 1'b0;
`endif

endmodule

// File: doc/alsu_arbiter.md
# alsu_arbiter

Round-robin arbiter and sequencer that shares one ALSU instance between `NUM_REQ` requesters. It accepts one operation at a time over a valid/ready handshake and drives the ALSU operand and control inputs. It waits the ALSU's fixed pipeline latency, captures `out` (and, optionally, the `leds` error indication), and returns a tagged response with backpressure. It sits between the requester logic and the ALSU's DUT modport inputs and outputs.

## Interface

Parameters:
- `NUM_REQ`, default 2. Number of requesters, range 2..8.
- `ALSU_LAT`, default 2. Cycles from the ALSU input sampling edge to `out` being valid.
- `ID_W`, default `$clog2(NUM_REQ)`. Width of the response tag. Derived; do not override.

Ports:
- `clk`  in  1  clock; all logic on posedge.
- `reset`  in  1  synchronous, active-low reset.
- `req_valid`  in  `NUM_REQ`  per-requester operation request.
- `req_ready`  out  `NUM_REQ`  per-requester accept; one-hot or zero.
- `req_opcode`  in  `[NUM_REQ-1:0][2:0]`  operation code.
- `req_a`, `req_b`  in  `[NUM_REQ-1:0]` signed [2:0]  operands.
- `req_ctrl`  in  `[NUM_REQ-1:0]` `alsu_ctrl_t` (7 bits)  control bits: [6] cin, [5] serial_in, [4] direction, [3] red_op_A, [2] red_op_B, [1] bypass_A, [0] bypass_B.
- `alsu_opcode`  out  3  to ALSU `opcode`.
- `alsu_a`, `alsu_b`  out  signed 3  to ALSU `A`, `B`.
- `alsu_ctrl`  out  7  to the ALSU control inputs, in the bit order above.
- `alsu_out`  in  6  from ALSU `out`.
- `alsu_leds`  in  16  from ALSU `leds`.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  response consumer accept.
- `rsp_id`  out  `ID_W`  index of the requester that issued the operation.
- `rsp_out`  out  6  captured ALSU result.
- `rsp_err`  out  1  invalid-operation flag (see Configuration).

## Operation

- FSM states: `IDLE` → `ISSUE` → `WAIT` → `RESP` → `IDLE`.
- `IDLE`:
  - Round-robin grant among asserted `req_valid`, searching from `last_grant+1` with wrap-around.
  - `req_ready[g]` = 1 only for the granted index `g`, combinationally, only while in `IDLE`.
  - Handshake completes when `req_valid[g] & req_ready[g]`. On that edge: latch the payload into the `alsu_*` registers, latch `g` into `rsp_id` and `last_grant`, and go to `ISSUE`.
  - With no valid requests, stay in `IDLE`.
- `ISSUE`: lasts exactly 1 cycle; `alsu_*` held stable. Load `wait_cnt = ALSU_LAT-1`, then go to `WAIT`.
- `WAIT`:
  - `alsu_*` held stable.
  - Decrement `wait_cnt` each cycle.
  - At `wait_cnt == 0`: capture `alsu_out` into `rsp_out` and the error flag into `rsp_err`, then go to `RESP`.
- `RESP`:
  - `rsp_valid` = 1; `rsp_id`, `rsp_out` and `rsp_err` are stable while `rsp_valid & !rsp_ready`.
  - On `rsp_ready`, go to `IDLE`.
- `alsu_*` outputs retain their last values in `IDLE` and `RESP`; they are never changed except on an accept.
- Requesters hold `req_valid` and their payload stable until accepted. A requester that drops `req_valid` before accept is simply not granted.
- Simultaneous requests: exactly one is granted per accept. The pointer advances only on an accept.

## Timing

- Reset (`reset == 0` at a posedge), from any state, including mid-`WAIT`:
  - state → `IDLE`; `last_grant` → `NUM_REQ-1`, so requester 0 has first priority.
  - `alsu_opcode`, `alsu_a`, `alsu_b`, `alsu_ctrl` → 0; `rsp_valid` → 0; `rsp_id`, `rsp_out`, `rsp_err` → 0.
  - `req_ready` = 0 in the cycle `reset` is low.
  - An in-flight operation is discarded; no response is produced.
- Accept in cycle T:
  - `alsu_*` valid from T+1.
  - `ISSUE` = T+1; `WAIT` = T+2 .. T+1+`ALSU_LAT`.
  - Capture at the end of cycle T+1+`ALSU_LAT`.
  - `rsp_valid` rises in cycle T+2+`ALSU_LAT` (T+4 at default).
- Back-to-back operations with `rsp_ready` tied high: one accept every `ALSU_LAT+3` cycles (5 at default).
- `ALSU_LAT == 1`: `WAIT` lasts one cycle. No zero-latency mode.

## Configuration

- Macro `ALSU_ARB_ERR_EN`.
- Defined: `rsp_err` = (`alsu_leds != 16'h0`), sampled at the same edge as `rsp_out`. This flags the ALSU invalid-operation blink: opcode 6 or 7, or a reduction op with an opcode other than OR/XOR.
- Not defined: `rsp_err` is tied to 0, `alsu_leds` is unused, and no error register is synthesized.

## Structure

- Package `alsu_arb_pkg`:
  - `alsu_ctrl_t` (packed struct, bit order above).
  - State enum `arb_state_e` {`IDLE`, `ISSUE`, `WAIT`, `RESP`}.
  - Opcode localparams `OP_OR`=0, `OP_XOR`=1, `OP_ADD`=2, `OP_MULT`=3, `OP_SHIFT`=4, `OP_ROTATE`=5.
- Sub-module `rr_arbiter` (parameterized by `NUM_REQ`): inputs `req`, `last_grant`; outputs one-hot `grant` and encoded `grant_idx`. Purely combinational. The pointer register lives in `alsu_arbiter`.

## Test plan

- Single request, default params:
  - Stimulus: req0 with opcode 2 (ADD), A=3, B=-2, cin=0, accepted at T.
  - Expected: `alsu_*` valid at T+1; `rsp_valid` at T+4 with `rsp_id`=0 and `rsp_out`=6'b000001.
- Both requesters hold `req_valid` continuously from reset:
  - Expected grants alternate 0, 1, 0, 1.
  - Expected `rsp_id` sequence 0, 1, 0, 1, with accepts 5 cycles apart.
- Backpressure:
  - Stimulus: `rsp_ready` held low for 4 cycles in `RESP`.
  - Expected: `rsp_valid`, `rsp_id` and `rsp_out` stable; `req_ready` stays 0; completion the cycle `rsp_ready` rises.
- Reset mid-operation:
  - Stimulus: `reset` low during the second `WAIT` cycle.
  - Expected next cycle: all outputs 0, state `IDLE`, no response ever emitted; requester 0 gets first grant after release.
- With `ALSU_ARB_ERR_EN` defined:
  - Stimulus: opcode 6, and the ALSU model drives `leds`=16'hFFFF.
  - Expected: `rsp_err`=1.
  - Without the macro: same stimulus gives `rsp_err`=0.
- `NUM_REQ`=4:
  - Stimulus: requests on 1 and 3 only, `last_grant`=1.
  - Expected: requester 3 granted next, then 1.
